// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory access unit
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // A request is rejected for an illegal size, natural misalignment, or an address past the memory.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] limit);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
               (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian lane extract/extend for loads and merge for sub-word stores
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane of the read word, then extend it (loads) or overwrite it (stores).
    always_comb begin
        byte_lane   = rd_word_i[{addr_lo_i, 3'b000} +: 8];
        half_lane   = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        load_data_o = rd_word_i;
        merged_o    = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
                merged_o    = rd_word_i;
                merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
                merged_o    = rd_word_i;
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0] = wdata_i[15:0];
                end
            end
            default: begin
                load_data_o = rd_word_i;
                merged_o    = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store initiator driving a sync-write, comb-read data memory
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    dmem_state_e state_q;
    dmem_req_t   req_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        mem_we_q;
    logic [31:0] mem_a_q;
    logic [31:0] mem_wd_q;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Lane logic always works on the latched request and the live memory read port.
    dmem_lane_align u_lane (
        .size_i      (req_q.size),
        .addr_lo_i   (req_q.addr[1:0]),
        .unsigned_i  (req_q.is_unsigned),
        .rd_word_i   (mem_rd_i),
        .wdata_i     (req_q.wdata),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    // Single FSM: request latch, response register and registered memory strobes move together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_q <= '{we: req_we_i, size: req_size_i, is_unsigned: req_unsigned_i,
                                   addr: req_addr_i, wdata: req_wdata_i};
                        if (req_is_bad(req_size_i, req_addr_i, ADDR_LIMIT)) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end else if (req_we_i && (req_size_i == SZ_WORD)) begin
                            mem_we_q <= 1'b1;
                            mem_a_q  <= {req_addr_i[31:2], 2'b00};
                            mem_wd_q <= req_wdata_i;
                            state_q  <= ST_WRITE;
                        end else begin
                            // Loads and sub-word stores both need the current word first.
                            mem_a_q <= {req_addr_i[31:2], 2'b00};
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (req_q.we) begin
                        mem_we_q <= 1'b1;
                        mem_a_q  <= {req_q.addr[31:2], 2'b00};
                        mem_wd_q <= merged;
                        state_q  <= ST_WRITE;
                    end else begin
                        mem_a_q     <= '0;
                        rsp_rdata_q <= load_data;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    mem_we_q    <= 1'b0;
                    mem_a_q     <= '0;
                    mem_wd_q    <= '0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_we_o    = mem_we_q;
    assign mem_a_o     = mem_a_q;
    assign mem_wd_o    = mem_wd_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized self-checking bench with a behavioural memory reference
module tb_dmem_access_unit;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        mem_init;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .mem_we_o       (mem_we),
        .mem_a_o        (mem_a),
        .mem_wd_o       (mem_wd),
        .mem_rd_i       (mem_rd)
    );

    // The attached data_memory: combinational read, write on the rising edge.
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: architectural effect of one request on the expected memory image.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata, output int lat);
        int unsigned idx, sh, nbytes;
        logic [31:0] v, mask;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr >= MEM_WORDS * 4);
        rdata = 32'd0;
        lat   = 1;
        if (err) return;
        idx    = addr / 4;
        sh     = 8 * (addr % 4);
        nbytes = 1 << size;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        if (!we) begin
            v = (ref_mem[idx] >> sh) & mask;
            if (!uns && nbytes == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
            if (!uns && nbytes == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            rdata = v;
            lat   = 2;
        end else begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
            lat = (nbytes == 4) ? 2 : 3;
        end
    endfunction

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, lat, nwe;
        logic        got;
        model(we, size, uns, addr, wdata, e_err, e_rd, e_lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; rsp_ready = (hold == 0);
        chk("req_ready_idle", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nwe = 0; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                nwe++;
                chk("mem_a_aligned", mem_a, {addr[31:2], 2'b00});
            end
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_seen", got, 1'b1);
        chk("latency", lat, e_lat);
        chk("we_cycles", nwe, (we && !e_err) ? 1 : 0);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_rdata", rsp_rdata, e_rd);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
                req_addr = 32'd0; req_wdata = 32'hFFFF_FFFF;
            end
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_rdata", rsp_rdata, e_rd);
            chk("hold_ready", req_ready, 1'b0);
            chk("hold_no_we", mem_we, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_rsp", req_ready, 1'b1);
        chk("rsp_valid_drop", rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        rst_n = 1'b1;

        run_req(1'b1, 2'd2, 1'b0, 32'd4, 32'd50, 0);
        run_req(1'b1, 2'd2, 1'b0, 32'd8, 32'd100, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 0);
        run_req(1'b1, 2'd2, 1'b0, 32'd12, 32'h1122_3344, 0);
        run_req(1'b1, 2'd0, 1'b0, 32'd13, 32'h0000_00AB, 0);
        chk("byte_merge_mem12", mem[3], 32'h1122_AB44);
        run_req(1'b0, 2'd0, 1'b0, 32'd13, 32'd0, 0);
        run_req(1'b0, 2'd0, 1'b1, 32'd13, 32'd0, 0);
        run_req(1'b1, 2'd1, 1'b0, 32'd18, 32'h0000_8001, 0);
        run_req(1'b0, 2'd1, 1'b0, 32'd18, 32'd0, 0);
        run_req(1'b0, 2'd1, 1'b1, 32'd18, 32'd0, 0);
        chk("half_merge_mem16", mem[4], ref_mem[4]);
        run_req(1'b0, 2'd2, 1'b0, 32'd6, 32'd0, 0);
        run_req(1'b0, 2'd1, 1'b0, 32'd3, 32'd0, 0);
        run_req(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, 0);
        run_req(1'b0, 2'd2, 1'b0, MEM_WORDS * 4, 32'd0, 0);
        run_req(1'b1, 2'd2, 1'b0, MEM_WORDS * 4, 32'h1234_5678, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 5);

        // Reset in the middle of a word-store WRITE cycle must not commit it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'd20; req_wdata = 32'hDEAD_BEEF; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_rst_we", mem_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", mem_we, 1'b0);
        chk("mid_rst_mem_a", mem_a, 32'd0);
        chk("mid_rst_mem_wd", mem_wd, 32'd0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_rsp_err", rsp_err, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_commit_mem20", mem[5], ref_mem[5]);
        chk("post_rst_req_ready", req_ready, 1'b1);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);

        for (int n = 0; n < 200; n++) begin
            run_req(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                    32'($urandom_range(0, 263)), $urandom, 0);
        end

        for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
